// File: rtl/vga_pkg.sv
// Shared definitions for the framebuffer display core: VGA timing, CI opcodes,
// instruction-FSM states and the colour configuration record.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_CFG  = 2'b10;
    localparam logic [1:0] OP_STAT = 2'b11;

    typedef enum logic [1:0] {
        CI_IDLE,
        CI_DONE,
        CI_RD_WAIT,
        CI_RD_DONE
    } ci_state_e;

    typedef struct packed {
        logic [2:0] fg;
        logic [2:0] bg;
        logic [2:0] border;
        logic       disp_en;
    } colour_cfg_t;

    localparam colour_cfg_t CFG_RESET = '{fg: 3'b111, bg: 3'b000, border: 3'b010, disp_en: 1'b1};

endpackage

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counters advanced on the pixel tick, with raw (undelayed)
// active-low syncs, active-area flag and a one-clk frame-wrap pulse.
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       active,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_wrap
);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       h_last, v_last;

    assign h_last = (h_cnt_q == 10'(H_TOTAL - 1));
    assign v_last = (v_cnt_q == 10'(V_TOTAL - 1));

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt      = h_cnt_q;
    assign v_cnt      = v_cnt_q;
    assign active     = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
    assign hsync_n    = !((h_cnt_q >= 10'(H_ACTIVE + H_FP)) &&
                          (h_cnt_q <  10'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_n    = !((v_cnt_q >= 10'(V_ACTIVE + V_FP)) &&
                          (v_cnt_q <  10'(V_ACTIVE + V_FP + V_SYNC)));
    assign frame_wrap = tick && h_last && v_last;

endmodule

// File: rtl/vga_fb_display.sv
// Framebuffer display core: image RAM scanned out (scaled/placed) on 640x480@60,
// with Nios II custom-instruction write/read/config/status access.
module vga_fb_display
    import vga_pkg::*;
#(
    parameter int unsigned IMG_W_LOG2 = 6,
    parameter int unsigned IMG_H_LOG2 = 6,
    parameter int unsigned PIX_BITS   = 1,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned X0         = 0,
    parameter int unsigned Y0         = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    input  logic        start,
    input  logic        clk_en,
    output logic [31:0] result,
    output logic        done,
    output logic [2:0]  pixel,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam int unsigned ADDR_W = IMG_W_LOG2 + IMG_H_LOG2;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned WIN_W  = (1 << IMG_W_LOG2) << SCALE_LOG2;
    localparam int unsigned WIN_H  = (1 << IMG_H_LOG2) << SCALE_LOG2;

    logic              tick_q, tick_d;
    logic [9:0]        h_cnt, v_cnt;
    logic              active, hsync_raw, vsync_raw, frame_wrap;
    logic [31:0]       off_x, off_y;
    logic              in_win, in_vblank;
    logic [ADDR_W-1:0] disp_addr, ci_addr;
    logic [1:0]        op;
    logic              accept, mem_we, ci_rd_en;
    logic              unused_bits;

    ci_state_e         state_q, state_d;
    logic [31:0]       result_q, result_d;
    colour_cfg_t       cfg_q, cfg_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic [PIX_BITS-1:0] mem [DEPTH];
    logic [PIX_BITS-1:0] disp_rd_q, ci_rd_q;

    logic       s1_active_q, s1_active_d, s1_win_q, s1_win_d;
    logic       s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic [2:0] pixel_q, pixel_d;
    logic       hs_q, hs_d, vs_q, vs_d;

    // Pixel tick is a clock enable on every second clk, never a derived clock.
    always_comb tick_d = ~tick_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tick_q <= 1'b0;
        else        tick_q <= tick_d;
    end

    vga_timing_gen u_timing (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick_q),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .active     (active),
        .hsync_n    (hsync_raw),
        .vsync_n    (vsync_raw),
        .frame_wrap (frame_wrap)
    );

    // Offsets wrap to huge values left/above the window, so one compare per axis suffices.
    always_comb begin
        off_x     = {22'b0, h_cnt} - X0;
        off_y     = {22'b0, v_cnt} - Y0;
        in_win    = (off_x < WIN_W) && (off_y < WIN_H);
        in_vblank = (v_cnt >= 10'(V_ACTIVE));
        disp_addr = {IMG_H_LOG2'(off_y >> SCALE_LOG2), IMG_W_LOG2'(off_x >> SCALE_LOG2)};
    end

    assign op          = dataa[31:30];
    assign ci_addr     = dataa[ADDR_W-1:0];
    assign accept      = clk_en && start && (state_q == CI_IDLE);
    assign mem_we      = accept && (op == OP_WR);
    assign ci_rd_en    = accept && (op == OP_RD);
    assign unused_bits = ^{dataa[29:ADDR_W], datab[31:10]};

    // Display and CI reads each get a registered port; the array maps to RAM copies.
    always_ff @(posedge clk) begin
        if (mem_we)   mem[ci_addr] <= datab[PIX_BITS-1:0];
        if (tick_q)   disp_rd_q    <= mem[disp_addr];
        if (ci_rd_en) ci_rd_q      <= mem[ci_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= CI_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clk_en) begin
            unique case (state_q)
                CI_IDLE:    if (start) state_d = (op == OP_RD) ? CI_RD_WAIT : CI_DONE;
                CI_RD_WAIT: state_d = CI_RD_DONE;
                CI_DONE:    state_d = CI_IDLE;
                CI_RD_DONE: state_d = CI_IDLE;
                default:    state_d = CI_IDLE;
            endcase
        end
    end

    always_comb begin
        done = 1'b0;
        if (clk_en && ((state_q == CI_DONE) || (state_q == CI_RD_DONE))) done = 1'b1;
    end

    always_comb begin
        result_d    = result_q;
        cfg_d       = cfg_q;
        frame_cnt_d = frame_cnt_q + {15'b0, frame_wrap};
        if (accept) begin
            unique case (op)
                OP_WR:   result_d = '0;
                OP_CFG: begin
                    result_d = '0;
                    cfg_d    = '{fg: datab[2:0], bg: datab[5:3], border: datab[8:6], disp_en: datab[9]};
                end
                OP_STAT: result_d = {frame_cnt_q, 14'b0, in_vblank, in_win};
                default: result_d = result_q;
            endcase
        end
        if (clk_en && (state_q == CI_RD_WAIT)) result_d = 32'(ci_rd_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q    <= '0;
            cfg_q       <= CFG_RESET;
            frame_cnt_q <= '0;
        end else begin
            result_q    <= result_d;
            cfg_q       <= cfg_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Two-tick pipeline: flags ride alongside the RAM read, colour mux registers into pixel.
    always_comb begin
        s1_active_d = s1_active_q;
        s1_win_d    = s1_win_q;
        s1_hs_d     = s1_hs_q;
        s1_vs_d     = s1_vs_q;
        pixel_d     = pixel_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        if (tick_q) begin
            s1_active_d = active;
            s1_win_d    = in_win;
            s1_hs_d     = hsync_raw;
            s1_vs_d     = vsync_raw;
            hs_d        = s1_hs_q;
            vs_d        = s1_vs_q;
            pixel_d     = '0;
            if (s1_active_q) begin
                if (!cfg_q.disp_en || !s1_win_q) pixel_d = cfg_q.border;
                else if (PIX_BITS == 1)          pixel_d = disp_rd_q[0] ? cfg_q.fg : cfg_q.bg;
                else                             pixel_d = 3'(disp_rd_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_active_q <= 1'b0;
            s1_win_q    <= 1'b0;
            s1_hs_q     <= 1'b1;
            s1_vs_q     <= 1'b1;
            pixel_q     <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
        end else begin
            s1_active_q <= s1_active_d;
            s1_win_q    <= s1_win_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            pixel_q     <= pixel_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
        end
    end

    assign result    = result_q;
    assign pixel     = pixel_q;
    assign hsync_out = hs_q;
    assign vsync_out = vs_q;

endmodule

// File: tb/tb_vga_fb_display.sv
// Directed/randomised bench for vga_fb_display: mono image, 2x scale at (0,0),
// display checked per clk against a raster model of the screen.
module tb_vga_fb_display;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataa, datab;
    logic        start, clk_en;
    logic [31:0] result;
    logic        done;
    logic [2:0]  pixel;
    logic        hsync_out, vsync_out;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned edge_cnt;
    int unsigned first_hs, second_hs;
    logic        prev_hs;

    logic        m_mem [4096];
    logic [2:0]  m_fg, m_bg, m_border;
    logic        m_disp_en;

    logic [31:0] r, a;
    int unsigned lat, ndone, n, p, x, y;
    logic        v;

    vga_fb_display #(
        .IMG_W_LOG2 (6),
        .IMG_H_LOG2 (6),
        .PIX_BITS   (1),
        .SCALE_LOG2 (1),
        .X0         (0),
        .Y0         (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dataa     (dataa),
        .datab     (datab),
        .start     (start),
        .clk_en    (clk_en),
        .result    (result),
        .done      (done),
        .pixel     (pixel),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
    );

    always #10 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Screen model: output after pixel tick k shows raster position k-2.
    function automatic logic [2:0] exp_pix(input int unsigned k);
        int unsigned pp, xx, yy;
        if (k < 2) return 3'b000;
        pp = (k - 2) % 420000;
        xx = pp % 800;
        yy = pp / 800;
        if (xx >= 640 || yy >= 480) return 3'b000;
        if (!m_disp_en) return m_border;
        if (xx < 128 && yy < 128) return m_mem[(yy / 2) * 64 + xx / 2] ? m_fg : m_bg;
        return m_border;
    endfunction

    function automatic logic exp_hs(input int unsigned k);
        int unsigned xx;
        if (k < 2) return 1'b1;
        xx = ((k - 2) % 420000) % 800;
        return !(xx >= 656 && xx < 752);
    endfunction

    function automatic logic exp_vs(input int unsigned k);
        int unsigned yy;
        if (k < 2) return 1'b1;
        yy = ((k - 2) % 420000) / 800;
        return !(yy >= 490 && yy < 492);
    endfunction

    task automatic watch(input int unsigned nclk);
        int unsigned k;
        for (int unsigned i = 0; i < nclk; i++) begin
            @(negedge clk);
            k = edge_cnt / 2;
            check("pixel", 32'(pixel), 32'(exp_pix(k)));
            check("hsync", 32'(hsync_out), 32'(exp_hs(k)));
            check("vsync", 32'(vsync_out), 32'(exp_vs(k)));
            if (prev_hs && !hsync_out) begin
                if (first_hs == 0)       first_hs  = edge_cnt;
                else if (second_hs == 0) second_hs = edge_cnt;
            end
            prev_hs = hsync_out;
        end
    endtask

    task automatic ci_write(input logic [31:0] addr, input logic val);
        @(negedge clk);
        dataa  = {OP_WR, addr[29:0]};
        datab  = {31'b0, val};
        start  = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("wr_done", 32'(done), 32'd1);
        check("wr_result", result, 32'd0);
        m_mem[addr % 4096] = val;
    endtask

    task automatic ci_read(input logic [31:0] addr, input int unsigned stall, input bit hold,
                           output logic [31:0] rd, output int unsigned lt, output int unsigned nd);
        @(negedge clk);
        dataa  = {OP_RD, addr[29:0]};
        datab  = $urandom;
        start  = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        lt = 1;
        nd = 0;
        if (stall != 0) begin
            clk_en = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                lt++;
            end
            clk_en = 1'b1;
        end
        while (!done && lt < 40) begin
            @(negedge clk);
            lt++;
        end
        rd = result;
        if (done) nd = 1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) nd++;
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        clk_en    = 1'b0;
        dataa     = '0;
        datab     = '0;
        m_fg      = 3'b111;
        m_bg      = 3'b000;
        m_border  = 3'b010;
        m_disp_en = 1'b1;
        first_hs  = 0;
        second_hs = 0;
        prev_hs   = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_hsync", 32'(hsync_out), 32'd1);
        check("rst_vsync", 32'(vsync_out), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b1;

        for (int unsigned i = 0; i < 4096; i++) begin
            v = 1'($urandom % 2);
            if (i == 0 || i == 5) v = 1'b1;
            if (i == 1 || i == 6) v = 1'b0;
            ci_write(32'(i), v);
        end

        ci_read(32'h005, 0, 1'b0, r, lat, ndone);
        check("rd5_data", r, 32'd1);
        check("rd5_latency", 32'(lat), 32'd2);
        check("rd5_single_done", 32'(ndone), 32'd1);
        ci_read(32'h006, 0, 1'b0, r, lat, ndone);
        check("rd6_data", r, 32'd0);

        for (int unsigned i = 0; i < 40; i++) begin
            a = $urandom & 32'h3FFF_FFFF;
            ci_read(a, 0, 1'b0, r, lat, ndone);
            check("rd_rand_data", r, {31'b0, m_mem[a % 4096]});
            check("rd_rand_latency", 32'(lat), 32'd2);
        end

        ci_write(32'h0ABC_D007, ~m_mem[7]);
        ci_read(32'h0000_0007, 0, 1'b0, r, lat, ndone);
        check("wr_wrap_data", r, {31'b0, m_mem[7]});

        ci_read(32'h005, 0, 1'b1, r, lat, ndone);
        check("hold_start_done_count", 32'(ndone), 32'd1);
        check("hold_start_data", r, 32'd1);
        ci_read(32'h005, 5, 1'b0, r, lat, ndone);
        check("stall_latency", 32'(lat), 32'd7);
        check("stall_done_count", 32'(ndone), 32'd1);
        check("stall_data", r, 32'd1);

        // A WRITE offered while a READ is in flight must be dropped entirely.
        @(negedge clk);
        dataa  = {OP_RD, 30'h005};
        start  = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);
        dataa = {OP_WR, 30'h009};
        datab = {31'b0, ~m_mem[9]};
        @(negedge clk);
        start = 1'b0;
        check("busy_rd_done", 32'(done), 32'd1);
        check("busy_rd_data", result, 32'd1);
        ci_read(32'h009, 0, 1'b0, r, lat, ndone);
        check("busy_wr_ignored", r, {31'b0, m_mem[9]});

        // Restart the raster, then reset again mid-line with a nonzero result pending.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ci_read(32'h000, 0, 1'b0, r, lat, ndone);
        check("rd0_data", r, 32'd1);
        watch(2 * (800 + 300) - edge_cnt);
        check("pre_reset_pixel_border", 32'(pixel), 32'b010);
        reset = 1'b0;
        #1;
        check("midframe_rst_pixel", 32'(pixel), 32'd0);
        check("midframe_rst_hsync", 32'(hsync_out), 32'd1);
        check("midframe_rst_vsync", 32'(vsync_out), 32'd1);
        check("midframe_rst_done", 32'(done), 32'd0);
        check("midframe_rst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        first_hs  = 0;
        second_hs = 0;
        prev_hs   = 1'b1;

        watch(20 * 1600);
        // Sync leaves the 2-tick pipeline 656+2 ticks after release.
        check("first_hsync_ticks", first_hs / 2, 32'd658);
        check("hsync_period_clk", second_hs - first_hs, 32'd1600);

        @(negedge clk);
        dataa  = {OP_CFG, 30'h0};
        datab  = 32'h0000_01C9;
        start  = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cfg_done", 32'(done), 32'd1);
        check("cfg_result", result, 32'd0);
        m_fg      = 3'b001;
        m_bg      = 3'b001;
        m_border  = 3'b111;
        m_disp_en = 1'b0;
        repeat (6) @(negedge clk);
        prev_hs = hsync_out;
        watch(2 * 1600);

        for (int unsigned i = 0; i < 4; i++) begin
            repeat ($urandom_range(1, 300)) @(negedge clk);
            n      = edge_cnt;
            dataa  = {OP_STAT, 30'h0};
            start  = 1'b1;
            clk_en = 1'b1;
            @(negedge clk);
            start = 1'b0;
            p = n / 2;
            x = p % 800;
            y = p / 800;
            check("stat_done", 32'(done), 32'd1);
            check("status", result, {16'h0, 14'h0, 1'(y >= 480), 1'(x < 128 && y < 128)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
